// File: rtl/fc1_mac.sv
// fc1_mac: fully connected MAC stage over the flattened pool2 stream.
// Each frame of NBEATS beats is multiplied by per-beat weight slices from a
// synchronous ROM and accumulated into NOUT dot products. On frame completion
// the scaled, saturated and optionally rectified vector is presented with a
// one-cycle ready pulse.
module fc1_mac #(
  parameter int NBITS  = 16,
  parameter int NFMAPS = 16,
  parameter int NBEATS = 25,
  parameter int NOUT   = 8,
  parameter int AW     = 5,
  parameter int ACCW   = 42,
  parameter int SHIFT  = 8,
  parameter int RELU   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           valid,
  input  logic                           flush,
  input  logic [NFMAPS*NBITS-1:0]        input_act,
  output logic [AW-1:0]                  w_addr,
  input  logic [NOUT*NFMAPS*NBITS-1:0]   w_data,
  output logic [NOUT*NBITS-1:0]          output_act,
  output logic                           ready
);

  localparam int              PSW      = 2*NBITS + $clog2(NFMAPS);
  localparam logic [AW-1:0]   LAST     = AW'(NBEATS - 1);
  localparam longint          SAT_HI_L = (longint'(1) << (NBITS - 1)) - 1;
  localparam logic signed [ACCW-1:0] SAT_HI = ACCW'(SAT_HI_L);
  localparam logic signed [ACCW-1:0] SAT_LO = ACCW'(-SAT_HI_L - 1);

  logic [AW-1:0]                cnt;
  logic [NFMAPS*NBITS-1:0]      act_ff;
  logic                         v1;
  logic                         first1;
  logic                         last1;
  logic signed [ACCW-1:0]       acc     [NOUT];
  logic signed [PSW-1:0]        partial [NOUT];
  logic signed [ACCW-1:0]       sum     [NOUT];
  logic signed [NBITS-1:0]      res     [NOUT];
  logic signed [2*NBITS-1:0]    prod;
  logic signed [ACCW-1:0]       shifted;
  logic [NOUT*NBITS-1:0]        out_q;
  logic                         ready_q;

  assign w_addr     = cnt;
  assign output_act = out_q;
  assign ready      = ready_q;

  // Dot products of the registered beat with the ROM slice, accumulation and output scaling
  always_comb begin
    prod    = '0;
    shifted = '0;
    for (int unsigned o = 0; o < NOUT; o++) begin
      partial[o] = '0;
      for (int unsigned i = 0; i < NFMAPS; i++) begin
        prod = $signed(act_ff[i*NBITS +: NBITS]) *
               $signed(w_data[(o*NFMAPS + i)*NBITS +: NBITS]);
        partial[o] = partial[o] + PSW'(prod);
      end
      sum[o]  = first1 ? ACCW'(partial[o]) : acc[o] + ACCW'(partial[o]);
      shifted = sum[o] >>> SHIFT;
      if (shifted > SAT_HI)
        res[o] = NBITS'(SAT_HI);
      else if (shifted < SAT_LO)
        res[o] = NBITS'(SAT_LO);
      else
        res[o] = shifted[NBITS-1:0];
      if (RELU != 0 && res[o][NBITS-1])
        res[o] = '0;
    end
  end

  // Beat counter and stage-1 input register; flush drops the concurrent beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      act_ff <= '0;
      v1     <= 1'b0;
      first1 <= 1'b0;
      last1  <= 1'b0;
    end else if (flush) begin
      cnt <= '0;
      v1  <= 1'b0;
    end else begin
      v1 <= valid;
      if (valid) begin
        act_ff <= input_act;
        first1 <= (cnt == '0);
        last1  <= (cnt == LAST);
        cnt    <= (cnt == LAST) ? '0 : cnt + AW'(1);
      end
    end
  end

  // Stage-2 accumulator update and frame result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned o = 0; o < NOUT; o++) acc[o] <= '0;
      out_q   <= '0;
      ready_q <= 1'b0;
    end else if (flush) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= v1 && last1;
      if (v1) begin
        for (int unsigned o = 0; o < NOUT; o++) acc[o] <= sum[o];
      end
      if (v1 && last1) begin
        for (int unsigned o = 0; o < NOUT; o++) out_q[o*NBITS +: NBITS] <= res[o];
      end
    end
  end

endmodule

// File: tb/tb_fc1_mac.sv
// tb_fc1_mac: two fc1_mac instances (unscaled/linear and default scaled/ReLU)
// share one stimulus stream; each has its own ROM port. Expected results come
// from a whole-frame dot-product model over the recorded beats.
module tb_fc1_mac;

  localparam int NB  = 16;
  localparam int NF  = 16;
  localparam int NBE = 25;
  localparam int NO  = 8;
  localparam int AW  = 5;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  valid;
  logic                  flush;
  logic [NF*NB-1:0]      input_act;
  logic [AW-1:0]         w_addr0, w_addr1;
  logic [NO*NF*NB-1:0]   w_data0, w_data1;
  logic [NO*NB-1:0]      out0, out1;
  logic                  ready0, ready1;

  logic [NO*NF*NB-1:0]   rom [0:31];

  fc1_mac #(.NBITS(NB), .NFMAPS(NF), .NBEATS(NBE), .NOUT(NO), .AW(AW),
            .ACCW(42), .SHIFT(0), .RELU(0)) dut0 (
    .clk(clk), .rst(rst), .valid(valid), .flush(flush), .input_act(input_act),
    .w_addr(w_addr0), .w_data(w_data0), .output_act(out0), .ready(ready0));

  fc1_mac #(.NBITS(NB), .NFMAPS(NF), .NBEATS(NBE), .NOUT(NO), .AW(AW),
            .ACCW(42), .SHIFT(8), .RELU(1)) dut1 (
    .clk(clk), .rst(rst), .valid(valid), .flush(flush), .input_act(input_act),
    .w_addr(w_addr1), .w_data(w_data1), .output_act(out1), .ready(ready1));

  always #5 clk = ~clk;

  // synchronous ROMs, one-cycle read latency
  always @(posedge clk) begin
    w_data0 <= rom[w_addr0];
    w_data1 <= rom[w_addr1];
  end

  typedef struct {
    int               due;
    logic [NO*NB-1:0] e0;
    logic [NO*NB-1:0] e1;
  } exp_t;

  exp_t             expq[$];
  logic [NF*NB-1:0] beats [NBE];
  logic [NO*NB-1:0] cur0, cur1;
  int               mcnt;
  int               cyc;
  int               n_cmp;
  int               n_bad;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [NO*NB-1:0] model(input int sh, input bit relu);
    logic [NO*NB-1:0] r;
    longint s;
    r = '0;
    for (int o = 0; o < NO; o++) begin
      s = 0;
      for (int b = 0; b < NBE; b++)
        for (int i = 0; i < NF; i++)
          s += longint'($signed(beats[b][i*NB +: NB])) *
               longint'($signed(rom[b][(o*NF + i)*NB +: NB]));
      s = s >>> sh;
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      if (relu && s < 0) s = 0;
      r[o*NB +: NB] = s[15:0];
    end
    return r;
  endfunction

  task automatic check_cycle();
    exp_t e;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      e = expq.pop_front();
      check("ready0", 128'(ready0), 128'(1'b1));
      check("ready1", 128'(ready1), 128'(1'b1));
      cur0 = e.e0;
      cur1 = e.e1;
    end else begin
      check("ready0_idle", 128'(ready0), 128'(1'b0));
      check("ready1_idle", 128'(ready1), 128'(1'b0));
    end
    check("out0", 128'(out0), 128'(cur0));
    check("out1", 128'(out1), 128'(cur1));
    check("w_addr0", 128'(w_addr0), 128'(mcnt));
    check("w_addr1", 128'(w_addr1), 128'(mcnt));
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      valid     = 1'b0;
      input_act = {8{$urandom}};
      tick();
    end
  endtask

  task automatic beat(input logic [NF*NB-1:0] a);
    exp_t e;
    input_act   = a;
    valid       = 1'b1;
    beats[mcnt] = a;
    if (mcnt == NBE - 1) begin
      e.due = cyc + 2;
      e.e0  = model(0, 1'b0);
      e.e1  = model(8, 1'b1);
      expq.push_back(e);
      mcnt = 0;
    end else begin
      mcnt++;
    end
    tick();
    valid = 1'b0;
  endtask

  task automatic frame(input logic [NB-1:0] v, input int gap);
    for (int b = 0; b < NBE; b++) begin
      beat({NF{v}});
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic rom_const(input logic [NB-1:0] v);
    for (int a = 0; a < 32; a++) rom[a] = {NO*NF{v}};
  endtask

  task automatic do_reset();
    valid = 1'b0;
    flush = 1'b0;
    rst   = 1'b1;
    #1;
    mcnt = 0;
    expq.delete();
    cur0 = '0;
    cur1 = '0;
    check("rst_out0", 128'(out0), 128'(0));
    check("rst_out1", 128'(out1), 128'(0));
    check("rst_ready", 128'({ready0, ready1}), 128'(0));
    check("rst_waddr", 128'({w_addr0, w_addr1}), 128'(0));
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  function automatic logic [NB-1:0] rnd_val(input int mode);
    case (mode)
      0:       return NB'($urandom_range(0, 8)) - NB'(4);
      1:       return NB'($urandom_range(0, 255)) - NB'(128);
      default: return NB'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1; valid = 1'b0; flush = 1'b0; input_act = '0;
    n_cmp = 0; n_bad = 0; cyc = 0; mcnt = 0;
    cur0 = '0; cur1 = '0;
    rom_const(16'd1);
    @(negedge clk);
    do_reset();

    // unit frame, back to back
    frame(16'd1, 0);
    idle(3);

    // saturation high, then negative weights (linear clamps, ReLU zeroes)
    rom_const(16'h7fff);
    frame(16'h7fff, 0);
    idle(3);
    rom_const(16'h8000);
    frame(16'h7fff, 0);
    idle(3);

    // gapped stream
    rom_const(16'd1);
    frame(16'd1, 2);
    idle(3);

    // back-to-back frames, no carry-over
    frame(16'd1, 0);
    frame(16'd2, 0);
    idle(3);

    // reset mid-frame
    for (int b = 0; b < 10; b++) beat({NF{16'd1}});
    do_reset();
    frame(16'd1, 0);
    idle(3);

    // flush together with valid after 7 beats
    for (int b = 0; b < 7; b++) beat({NF{16'd1}});
    flush = 1'b1;
    valid = 1'b1;
    input_act = {NF{16'd5}};
    mcnt = 0;
    tick();
    flush = 1'b0;
    valid = 1'b0;
    frame(16'd1, 0);
    idle(3);

    // randomized frames with random weights, values and gaps
    for (int f = 0; f < 8; f++) begin
      int mode;
      logic [NF*NB-1:0] a;
      mode = f % 3;
      for (int r = 0; r < 32; r++)
        for (int k = 0; k < NO*NF; k++) rom[r][k*NB +: NB] = rnd_val(mode);
      for (int b = 0; b < NBE; b++) begin
        for (int i = 0; i < NF; i++) a[i*NB +: NB] = rnd_val(mode);
        beat(a);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      if ($urandom_range(0, 1) == 0) idle(2);
    end
    idle(5);

    check("pending_results", 128'(expq.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
